// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN,
        DONE
    } run_state_t;

    localparam int unsigned CT_W_DEFAULT = 16;
    localparam int unsigned NUM_BASES    = 3;

    // Start addresses of the selectable programs
    localparam int unsigned PROG_BASE [NUM_BASES] = '{0, 128, 256};

    // Start address for a program index; indices outside the valid range map to 0
    function automatic int unsigned prog_base_of(input logic [1:0] sel,
                                                 input int unsigned num_progs);
        int unsigned base;
        case (sel)
            2'd0:    base = PROG_BASE[0];
            2'd1:    base = PROG_BASE[1];
            2'd2:    base = PROG_BASE[2];
            default: base = 0;
        endcase
        if (32'(sel) >= num_progs) begin
            base = 0;
        end
        return base;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up on inc, stick at all-ones, clear has priority
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: selects the start PC, holds PC load for the init window,
// enables the core, drains memory writes after halt and flags completion.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned CT_W        = CT_W_DEFAULT,
    parameter int unsigned NUM_PROGS   = 3,
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 60000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      prog_sel,
    input  logic            halt,
    input  logic            mem_busy,
    output logic [PC_W-1:0] start_pc,
    output logic            pc_load,
    output logic            core_en,
    output logic            done,
    output logic            timeout,
    output logic [CT_W-1:0] cycle_ct
);

    localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    run_state_t    state;
    run_state_t    state_next;
    logic [IW-1:0] init_ct;
    logic          init_load;
    logic          init_dec;
    logic          latch_pc;
    logic          set_timeout;
    logic          ct_inc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle strobes for the datapath
    always_comb begin
        state_next  = state;
        init_load   = 1'b0;
        init_dec    = 1'b0;
        latch_pc    = 1'b0;
        set_timeout = 1'b0;
        ct_inc      = 1'b0;
        case (state)
            IDLE: begin
                state_next = INIT;
                init_load  = 1'b1;
                latch_pc   = 1'b1;
            end
            INIT: begin
                if (init_ct == '0) begin
                    state_next = RUN;
                end else begin
                    init_dec = 1'b1;
                end
            end
            RUN: begin
                ct_inc = 1'b1;
                // Halt outranks a timeout landing on the same cycle
                if (halt) begin
                    state_next = DRAIN;
                end else if (cycle_ct == CT_W'(TIMEOUT - 1)) begin
                    state_next  = DONE;
                    set_timeout = 1'b1;
                end
            end
            DRAIN: begin
                if (!mem_busy) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            start_pc <= '0;
            pc_load  <= 1'b0;
            core_en  <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            init_ct  <= '0;
        end else begin
            pc_load <= (state_next == INIT);
            core_en <= (state_next == RUN);
            done    <= (state_next == DONE);
            if (set_timeout) begin
                timeout <= 1'b1;
            end
            if (latch_pc) begin
                start_pc <= PC_W'(prog_base_of(prog_sel, NUM_PROGS));
            end
            if (init_load) begin
                init_ct <= IW'(INIT_CYCLES - 1);
            end else if (init_dec) begin
                init_ct <= init_ct - IW'(1);
            end
        end
    end

    sat_counter #(
        .W(CT_W)
    ) u_cycle_ct (
        .clk (clk),
        .clr (reset),
        .inc (ct_inc),
        .q   (cycle_ct)
    );

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  prog_sel;
    logic        halt;
    logic        mem_busy;
    logic [9:0]  start_pc;
    logic        pc_load;
    logic        core_en;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_ct;

    int checks = 0;
    int errors = 0;

    run_ctrl #(
        .PC_W        (10),
        .CT_W        (16),
        .NUM_PROGS   (3),
        .INIT_CYCLES (2),
        .TIMEOUT     (50)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .prog_sel (prog_sel),
        .halt     (halt),
        .mem_busy (mem_busy),
        .start_pc (start_pc),
        .pc_load  (pc_load),
        .core_en  (core_en),
        .done     (done),
        .timeout  (timeout),
        .cycle_ct (cycle_ct)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".start_pc"}, 32'(start_pc), 32'd0);
        chk({tag, ".pc_load"},  32'(pc_load),  32'd0);
        chk({tag, ".core_en"},  32'(core_en),  32'd0);
        chk({tag, ".done"},     32'(done),     32'd0);
        chk({tag, ".timeout"},  32'(timeout),  32'd0);
        chk({tag, ".cycle_ct"}, 32'(cycle_ct), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        prog_sel = 2'd1;
        halt     = 1'b0;
        mem_busy = 1'b0;
        tick(2);
        chk_all_zero("reset");

        // Program select 1, then halt after 10 RUN cycles with no drain
        reset = 1'b0;
        tick();
        chk("sel1.start_pc", 32'(start_pc), 32'd128);
        chk("sel1.pc_load1", 32'(pc_load),  32'd1);
        chk("sel1.core_en0", 32'(core_en),  32'd0);
        prog_sel = 2'd2;
        tick();
        chk("sel1.pc_load2", 32'(pc_load),  32'd1);
        chk("sel1.core_en1", 32'(core_en),  32'd0);
        tick();
        chk("sel1.pc_load3", 32'(pc_load),  32'd0);
        chk("sel1.core_en2", 32'(core_en),  32'd1);
        chk("sel1.ct0",      32'(cycle_ct), 32'd0);
        tick(9);
        chk("run.ct9",       32'(cycle_ct), 32'd9);
        chk("run.sel_hold",  32'(start_pc), 32'd128);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt.core_en",  32'(core_en),  32'd0);
        chk("halt.ct10",     32'(cycle_ct), 32'd10);
        chk("halt.done_e1",  32'(done),     32'd0);
        tick();
        chk("halt.done",     32'(done),     32'd1);
        chk("halt.timeout",  32'(timeout),  32'd0);
        chk("halt.ct_final", 32'(cycle_ct), 32'd10);
        tick(3);
        chk("halt.sticky",   32'(done),     32'd1);

        // Halt with memory busy for 3 more cycles
        prog_sel = 2'd0;
        pulse_reset();
        chk("drain.rst_done", 32'(done), 32'd0);
        tick(3);
        chk("drain.start_pc", 32'(start_pc), 32'd0);
        chk("drain.core_en",  32'(core_en),  32'd1);
        halt     = 1'b1;
        mem_busy = 1'b1;
        tick();
        halt = 1'b0;
        chk("drain.ct1",      32'(cycle_ct), 32'd1);
        chk("drain.core_off", 32'(core_en),  32'd0);
        tick(3);
        chk("drain.busy_done", 32'(done), 32'd0);
        mem_busy = 1'b0;
        tick();
        chk("drain.done",     32'(done),     32'd1);
        chk("drain.ct_hold",  32'(cycle_ct), 32'd1);

        // Timeout at 50 RUN cycles
        prog_sel = 2'd2;
        pulse_reset();
        tick(3);
        tick(49);
        chk("to.ct49",      32'(cycle_ct), 32'd49);
        chk("to.done49",    32'(done),     32'd0);
        tick();
        chk("to.done",      32'(done),     32'd1);
        chk("to.timeout",   32'(timeout),  32'd1);
        chk("to.ct50",      32'(cycle_ct), 32'd50);
        chk("to.core_en",   32'(core_en),  32'd0);
        tick(2);
        chk("to.ct_hold",   32'(cycle_ct), 32'd50);
        chk("to.to_hold",   32'(timeout),  32'd1);
        chk("to.pc_hold",   32'(start_pc), 32'd256);

        // Halt on the timeout cycle: halt wins
        pulse_reset();
        tick(3);
        tick(49);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("tohalt.ct50",    32'(cycle_ct), 32'd50);
        chk("tohalt.done_e1", 32'(done),     32'd0);
        chk("tohalt.to_e1",   32'(timeout),  32'd0);
        tick();
        chk("tohalt.done",    32'(done),     32'd1);
        chk("tohalt.timeout", 32'(timeout),  32'd0);

        // Reset in the middle of RUN
        prog_sel = 2'd0;
        pulse_reset();
        tick(3);
        tick(5);
        chk("mid.ct5", 32'(cycle_ct), 32'd5);
        reset = 1'b1;
        tick();
        chk_all_zero("mid");
        prog_sel = 2'd2;
        tick();
        reset = 1'b0;
        tick();
        chk("mid.start_pc", 32'(start_pc), 32'd256);
        chk("mid.pc_load",  32'(pc_load),  32'd1);

        // Invalid program index falls back to address 0
        prog_sel = 2'd3;
        pulse_reset();
        tick();
        chk("inv.start_pc", 32'(start_pc), 32'd0);
        chk("inv.pc_load",  32'(pc_load),  32'd1);

        // Three consecutive runs; RUN count restarts each time
        for (int r = 0; r < 3; r++) begin
            prog_sel = 2'(r);
            pulse_reset();
            tick();
            chk($sformatf("seq%0d.start_pc", r), 32'(start_pc),
                (r == 0) ? 32'd0 : (r == 1) ? 32'd128 : 32'd256);
            tick(2);
            chk($sformatf("seq%0d.ct0", r),     32'(cycle_ct), 32'd0);
            chk($sformatf("seq%0d.core_en", r), 32'(core_en),  32'd1);
            tick(r + 2);
            halt = 1'b1;
            tick();
            halt = 1'b0;
            tick();
            chk($sformatf("seq%0d.done", r), 32'(done),     32'd1);
            chk($sformatf("seq%0d.ct", r),   32'(cycle_ct), 32'(r + 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
